// File: rtl/mxu_skew_feeder_pkg.sv
// Shared constants, FSM encodings and helpers for the MXU skew feeder.
package mxu_skew_feeder_pkg;

    localparam int LANE_NUM      = 16;
    localparam int LANE_WIDTH    = 8;
    localparam int FIFO_DEPTH    = 4;
    localparam int ROW_CNT_WIDTH = 5;
    localparam int ROW_WIDTH     = LANE_NUM + LANE_NUM * LANE_WIDTH;

    typedef enum logic [1:0] {
        MXU_FEED_FSM_IDLE  = 2'b00,
        MXU_FEED_FSM_FEED  = 2'b01,
        MXU_FEED_FSM_DRAIN = 2'b10
    } feed_fsm_e;

    // A job never holds more rows than the wavefront has lanes.
    function automatic logic [ROW_CNT_WIDTH-1:0] sat_row_num(input logic [ROW_CNT_WIDTH-1:0] n);
        return (n > ROW_CNT_WIDTH'(LANE_NUM)) ? ROW_CNT_WIDTH'(LANE_NUM) : n;
    endfunction

endpackage

// File: rtl/mxu_skew_feeder_if.sv
// Row bus from the RAM buffer and skewed wavefront bus towards the MXU.
interface mxu_skew_feeder_if;
    import mxu_skew_feeder_pkg::*;

    logic [LANE_NUM-1:0]            ram_buff_mxu_vld;
    logic [LANE_NUM*LANE_WIDTH-1:0] ram_buff_mxu_data;
    logic                           mxu_stall;
    logic [LANE_NUM-1:0]            feed_mxu_vld;
    logic [LANE_NUM*LANE_WIDTH-1:0] feed_mxu_data;

    modport master (
        output ram_buff_mxu_vld, ram_buff_mxu_data, mxu_stall,
        input  feed_mxu_vld, feed_mxu_data
    );

    modport slave (
        input  ram_buff_mxu_vld, ram_buff_mxu_data, mxu_stall,
        output feed_mxu_vld, feed_mxu_data
    );

endinterface

// File: rtl/mxu_feed_fifo.sv
// Show-ahead row FIFO; a push coinciding with flush becomes the only entry.
module mxu_feed_fifo #(
    parameter int WIDTH = 144,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (flush || !full || pop);
    assign rd_en = pop && !empty && !flush;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= {{AW{1'b0}}, push};
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[flush ? '0 : wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mxu_skew_feeder.sv
// Buffers RAM rows and re-times them into a diagonal wavefront for the MXU.
// Define MXU_FEED_PERF_CNT_EN to add the feed_stall_cnt performance counter.
//
// state              | meaning
// MXU_FEED_FSM_IDLE  | no job; rows still land in the FIFO
// MXU_FEED_FSM_FEED  | popping rows until the job's row count is reached
// MXU_FEED_FSM_DRAIN | flushing LANE_NUM non-stalled cycles of skew stages
module mxu_skew_feeder
    import mxu_skew_feeder_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    mxu_skew_feeder_if.slave         bus,
    input  logic                     ctrl_feed_start,
    input  logic [ROW_CNT_WIDTH-1:0] ctrl_feed_row_num,
    output logic                     feed_busy,
    output logic                     feed_done,
    output logic                     feed_ovf
`ifdef MXU_FEED_PERF_CNT_EN
    ,
    output logic [15:0]              feed_stall_cnt
`endif
);
    feed_fsm_e                      state;
    logic [ROW_CNT_WIDTH-1:0]       row_num_ff;
    logic [ROW_CNT_WIDTH-1:0]       rows_popped;
    logic [ROW_CNT_WIDTH-1:0]       drain_cnt;
    logic [ROW_CNT_WIDTH-1:0]       row_num_sat;
    logic                           push;
    logic                           pop;
    logic                           restart;
    logic                           drop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [ROW_WIDTH-1:0]           fifo_rdata;
    logic [LANE_NUM-1:0]            pop_vld;
    logic [LANE_NUM*LANE_WIDTH-1:0] pop_data;
    logic [LANE_NUM-1:0]            out_vld;
    logic [LANE_NUM*LANE_WIDTH-1:0] out_data;

    assign push        = |bus.ram_buff_mxu_vld;
    assign restart     = ctrl_feed_start && (state != MXU_FEED_FSM_IDLE);
    assign row_num_sat = sat_row_num(ctrl_feed_row_num);
    assign pop         = !fifo_empty && (state == MXU_FEED_FSM_FEED) && !bus.mxu_stall
                         && (rows_popped < row_num_ff) && !ctrl_feed_start;
    assign drop        = push && fifo_full && !pop && !restart;
    assign {pop_vld, pop_data} = fifo_rdata;
    assign feed_busy   = (state != MXU_FEED_FSM_IDLE);

    mxu_feed_fifo #(
        .WIDTH (ROW_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (restart),
        .wdata ({bus.ram_buff_mxu_vld, bus.ram_buff_mxu_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Lane i owns i+1 stages; invalid lanes carry zero data from the entry point.
    for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
        logic [LANE_WIDTH:0] lane_in;
        logic [LANE_WIDTH:0] sr [0:i];

        assign lane_in = (pop && pop_vld[i])
                         ? {1'b1, pop_data[i*LANE_WIDTH +: LANE_WIDTH]} : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= i; s++) sr[s] <= '0;
            end else if (ctrl_feed_start) begin
                for (int s = 0; s <= i; s++) sr[s] <= '0;
            end else if (!bus.mxu_stall) begin
                sr[0] <= lane_in;
                for (int s = 1; s <= i; s++) sr[s] <= sr[s-1];
            end
        end

        assign out_vld[i] = sr[i][LANE_WIDTH] && !bus.mxu_stall;
        assign out_data[i*LANE_WIDTH +: LANE_WIDTH] = sr[i][LANE_WIDTH-1:0];
    end

    assign bus.feed_mxu_vld  = out_vld;
    assign bus.feed_mxu_data = out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MXU_FEED_FSM_IDLE;
            row_num_ff  <= '0;
            rows_popped <= '0;
            drain_cnt   <= '0;
            feed_done   <= 1'b0;
            feed_ovf    <= 1'b0;
        end else begin
            feed_done <= 1'b0;
            if (drop) feed_ovf <= 1'b1;
            if (ctrl_feed_start) begin
                row_num_ff  <= row_num_sat;
                rows_popped <= '0;
                drain_cnt   <= '0;
                feed_ovf    <= 1'b0;
                if (row_num_sat == '0) begin
                    state     <= MXU_FEED_FSM_IDLE;
                    feed_done <= 1'b1;
                end else begin
                    state <= MXU_FEED_FSM_FEED;
                end
            end else begin
                case (state)
                    MXU_FEED_FSM_IDLE: ;
                    MXU_FEED_FSM_FEED: begin
                        if (pop) begin
                            rows_popped <= rows_popped + ROW_CNT_WIDTH'(1);
                            if (rows_popped + ROW_CNT_WIDTH'(1) == row_num_ff)
                                state <= MXU_FEED_FSM_DRAIN;
                        end
                    end
                    MXU_FEED_FSM_DRAIN: begin
                        if (!bus.mxu_stall) begin
                            drain_cnt <= drain_cnt + ROW_CNT_WIDTH'(1);
                            if (drain_cnt == ROW_CNT_WIDTH'(LANE_NUM - 1)) begin
                                state     <= MXU_FEED_FSM_IDLE;
                                feed_done <= 1'b1;
                            end
                        end
                    end
                    default: state <= MXU_FEED_FSM_IDLE;
                endcase
            end
        end
    end

`ifdef MXU_FEED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feed_stall_cnt <= '0;
        end else if (ctrl_feed_start) begin
            feed_stall_cnt <= '0;
        end else if (bus.mxu_stall && (state != MXU_FEED_FSM_IDLE) && (feed_stall_cnt != 16'hFFFF)) begin
            feed_stall_cnt <= feed_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
